// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the LSU port arbiter: FSM states, RV32
// load/store funct3 encodings and requester port indices.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int PORT_CORE = 0;
  localparam int PORT_DBG  = 1;

  // Store encodings alias the load ones, so LH/LHU/LW cover SH/SW too.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    case (funct3)
      LH, LHU: r = addr_lo[0];
      LW:      r = |addr_lo;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_arb_prio.sv
// Fixed-priority grant (core over debug) with a saturating starvation
// counter that force-grants the debug port after STARVE_MAX lost rounds.
module lsu_arb_prio
  import lsu_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_valid_i,
  input  logic       arb_en_i,
  output logic [1:0] grant_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_starve;
  logic          w_force;

  assign w_force = (r_starve == CW'(STARVE_MAX));

  always_comb begin
    grant_o = 2'b00;
    if (arb_en_i) begin
      if (req_valid_i[PORT_DBG] && (!req_valid_i[PORT_CORE] || w_force))
        grant_o[PORT_DBG] = 1'b1;
      else if (req_valid_i[PORT_CORE])
        grant_o[PORT_CORE] = 1'b1;
    end
  end

  // Only rounds the debug port actually loses are counted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      r_starve <= '0;
    else if (!req_valid_i[PORT_DBG] || grant_o[PORT_DBG])
      r_starve <= '0;
    else if (grant_o[PORT_CORE] && !w_force)
      r_starve <= r_starve + 1'b1;
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-port arbiter in front of the single LSU port, one access in flight.
// Optional LSU_ARB_MISALIGN_CHK_EN adds rsp_err_o and short-circuits misaligned accesses.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0]       req_wren_i,
  input  logic [1:0][2:0]  req_funct3_i,
  input  logic [1:0][31:0] req_addr_i,
  input  logic [1:0][31:0] req_wdata_i,
  output logic [1:0]       rsp_valid_o,
  output logic [31:0]      rsp_rdata_o,
`ifdef LSU_ARB_MISALIGN_CHK_EN
  output logic             rsp_err_o,
`endif
  output logic             lsu_wren_o,
  output logic [2:0]       lsu_funct3_o,
  output logic [31:0]      lsu_addr_o,
  output logic [31:0]      lsu_st_data_o,
  input  logic [31:0]      lsu_ld_data_i
);

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_e      r_state, w_next;
  logic        r_port, r_wren;
  logic [2:0]  r_funct3, r_lat;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        w_arb_en, w_accept, w_sel, w_misalign, w_last_wait;
  logic [1:0]  w_grant;

  assign w_arb_en    = (r_state == IDLE) || (r_state == RESP);
  assign w_accept    = |w_grant;
  assign w_sel       = w_grant[PORT_DBG];
  assign w_last_wait = (r_state == WAIT) && (r_lat == LAT_LAST);

  lsu_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .arb_en_i    (w_arb_en),
    .grant_o     (w_grant)
  );

`ifdef LSU_ARB_MISALIGN_CHK_EN
  logic r_err;
  assign w_misalign = is_misaligned(req_funct3_i[w_sel], req_addr_i[w_sel][1:0]);
  assign rsp_err_o  = r_err && (r_state == RESP);
`else
  assign w_misalign = 1'b0;
`endif

  assign req_ready_o = w_grant & {2{rst_ni}};
  assign rsp_valid_o = (r_state == RESP && rst_ni) ? (r_port ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata_o = r_rdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) w_next = w_misalign ? RESP : ISSUE;
        else          w_next = IDLE;
      end
      ISSUE:   w_next = r_wren ? RESP : WAIT;
      WAIT:    if (w_last_wait) w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  // Idle/response cycles present address 0 so the LSU selects nothing.
  always_comb begin
    lsu_wren_o    = 1'b0;
    lsu_funct3_o  = 3'b000;
    lsu_addr_o    = 32'h0;
    lsu_st_data_o = 32'h0;
    if (r_state == ISSUE || r_state == WAIT) begin
      lsu_funct3_o  = r_funct3;
      lsu_addr_o    = r_addr;
      lsu_st_data_o = r_wdata;
    end
    if (r_state == ISSUE) lsu_wren_o = r_wren & rst_ni;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_rdata <= 32'h0;
      r_lat   <= 3'd0;
`ifdef LSU_ARB_MISALIGN_CHK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept)         r_rdata <= 32'h0;
      else if (w_last_wait) r_rdata <= lsu_ld_data_i;
      if (r_state == WAIT)  r_lat <= r_lat + 3'd1;
      else                  r_lat <= 3'd0;
`ifdef LSU_ARB_MISALIGN_CHK_EN
      if (w_accept) r_err <= w_misalign;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_port   <= w_sel;
      r_wren   <= req_wren_i[w_sel];
      r_funct3 <= req_funct3_i[w_sel];
      r_addr   <= req_addr_i[w_sel];
      r_wdata  <= req_wdata_i[w_sel];
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench for lsu_arbiter: transaction-age reference model plus
// directed literal scenarios and randomized two-port traffic.
module tb_lsu_arbiter;
  import lsu_arb_pkg::*;

  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [1:0]       v, wren, ready, rspv;
  logic [1:0][2:0]  f3;
  logic [1:0][31:0] addr, wd;
  logic [31:0]      rdata, ldd, laddr, lsd;
  logic [2:0]       lf3;
  logic             lwren;
`ifdef LSU_ARB_MISALIGN_CHK_EN
  logic             rerr;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  lsu_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i         (clk),
    .rst_ni        (rstn),
    .req_valid_i   (v),
    .req_ready_o   (ready),
    .req_wren_i    (wren),
    .req_funct3_i  (f3),
    .req_addr_i    (addr),
    .req_wdata_i   (wd),
    .rsp_valid_o   (rspv),
    .rsp_rdata_o   (rdata),
`ifdef LSU_ARB_MISALIGN_CHK_EN
    .rsp_err_o     (rerr),
`endif
    .lsu_wren_o    (lwren),
    .lsu_funct3_o  (lf3),
    .lsu_addr_o    (laddr),
    .lsu_st_data_o (lsd),
    .lsu_ld_data_i (ldd)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit misaligned(input logic [2:0] f, input logic [31:0] a);
`ifdef LSU_ARB_MISALIGN_CHK_EN
    bit half, word;
    half = (f == LH) || (f == LHU) || (f == SH);
    word = (f == LW) || (f == SW);
    return (half && a[0]) || (word && a[1:0] != 2'b00);
`else
    return (f == 3'b111) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  // Reference model: one transaction tracked by its age in cycles since accept.
  bit          m_busy, m_port, m_wren, m_err;
  int          m_age, m_starve;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wd, m_rd;
  logic [1:0]  m_acc;

  always @(negedge clk) begin
    logic [1:0]  eg, ev;
    logic        ew;
    logic [2:0]  ef;
    logic [31:0] ea, es;
    bit          open;
    int          ra;
    ra   = m_err ? 1 : (m_wren ? 2 : 2 + RD_LAT);
    open = !m_busy || (m_age == ra);
    eg = 2'b00; ev = 2'b00; ew = 1'b0; ef = 3'b000; ea = 32'h0; es = 32'h0;
    if (open) begin
      if (v[1] && (!v[0] || m_starve == STARVE_MAX)) eg = 2'b10;
      else if (v[0])                                 eg = 2'b01;
    end
    if (m_busy && !m_err && (m_age == 1 || (!m_wren && m_age <= 1 + RD_LAT))) begin
      ea = m_addr; ef = m_f3; es = m_wd;
      if (m_age == 1) ew = m_wren;
    end
    if (m_busy && m_age == ra) ev = m_port ? 2'b10 : 2'b01;
    if (!rstn) begin eg = 2'b00; ev = 2'b00; ew = 1'b0; end
    if (chk_en) begin
      chk("m_ready", 32'(ready), 32'(eg));
      chk("m_rsp_valid", 32'(rspv), 32'(ev));
      chk("m_lsu_wren", 32'(lwren), 32'(ew));
      chk("m_lsu_addr", laddr, ea);
      chk("m_lsu_funct3", 32'(lf3), 32'(ef));
      chk("m_lsu_st_data", lsd, es);
      if (ev != 2'b00) begin
        chk("m_rsp_rdata", rdata, m_rd);
`ifdef LSU_ARB_MISALIGN_CHK_EN
        chk("m_rsp_err", 32'(rerr), 32'(m_err));
`endif
      end
    end
    m_acc = eg;
    if (!rstn) begin
      m_busy = 0; m_starve = 0;
    end else begin
      if (m_busy && !m_wren && !m_err && m_age == 1 + RD_LAT) m_rd = ldd;
      if (open) begin
        if (!v[1] || eg[1])                   m_starve = 0;
        else if (eg[0] && m_starve < STARVE_MAX) m_starve++;
      end else if (!v[1]) m_starve = 0;
      if (m_busy && m_age == ra) m_busy = 0;
      if (m_busy) m_age++;
      if (eg != 2'b00) begin
        m_port = eg[1];
        m_wren = wren[eg[1]];
        m_f3   = f3[eg[1]];
        m_addr = addr[eg[1]];
        m_wd   = wd[eg[1]];
        m_err  = misaligned(m_f3, m_addr);
        m_rd   = 32'h0;
        m_busy = 1; m_age = 1;
      end
    end
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) begin nxt(); smp(); end endtask

  logic [2:0] ld_ops [5] = '{LB, LH, LW, LBU, LHU};
  logic [2:0] st_ops [3] = '{SB, SH, SW};

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, wrc;
    int seq [10];
    int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    rstn = 0; v = 0; wren = 0; f3 = '0; addr = '0; wd = '0; ldd = 0;
    m_busy = 0; m_starve = 0; m_acc = 0; m_err = 0; m_wren = 0; m_age = 0;
    repeat (2) nxt();
    chk_en = 1;
    smp();
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_rsp_valid", 32'(rspv), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_lsu_addr", laddr, 32'h0);
    chk("rst_lsu_wren", 32'(lwren), 32'h0);
    nxt(); rstn = 1; smp();

    // Core load, data valid only in the single WAIT cycle
    nxt(); v[0] = 1; wren[0] = 0; f3[0] = LW; addr[0] = 32'h0001_0010;
    smp(); chk("ld_accept", 32'(ready), 32'h1);
    nxt(); v[0] = 0;
    smp(); chk("ld_issue_addr", laddr, 32'h0001_0010); chk("ld_issue_wren", 32'(lwren), 32'h0);
    nxt(); ldd = 32'hDEAD_BEEF;
    smp(); chk("ld_wait_rsp", 32'(rspv), 32'h0);
    nxt(); ldd = 32'h0;
    smp(); chk("ld_rsp_valid", 32'(rspv), 32'h1); chk("ld_rsp_rdata", rdata, 32'hDEAD_BEEF);
    idle(2);

    // Debug store
    nxt(); v[1] = 1; wren[1] = 1; f3[1] = SW; addr[1] = 32'h0002_0000; wd[1] = 32'h0000_03FF;
    smp(); chk("st_accept", 32'(ready), 32'h2); chk("st_t0_wren", 32'(lwren), 32'h0);
    nxt(); v[1] = 0;
    smp(); chk("st_wren", 32'(lwren), 32'h1); chk("st_addr", laddr, 32'h0002_0000);
    chk("st_data", lsd, 32'h0000_03FF); chk("st_funct3", 32'(lf3), 32'h2);
    nxt();
    smp(); chk("st_rsp_valid", 32'(rspv), 32'h2); chk("st_rsp_addr0", laddr, 32'h0);
    chk("st_rsp_wren", 32'(lwren), 32'h0); chk("st_rsp_rdata", rdata, 32'h0);
    idle(2);

    // Contention: both ports hold stores continuously
    nxt(); v = 2'b11; wren = 2'b11; f3[0] = SW; f3[1] = SW;
    addr[0] = 32'h0000_1000; addr[1] = 32'h0000_2000; wd[0] = 32'h11; wd[1] = 32'h22;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      smp();
      if (ready[0]) begin seq[n] = 0; n++; end
      else if (ready[1]) begin seq[n] = 1; n++; end
      if (n == 10) break;
      nxt();
    end
    chk("cont_accepts", 32'(n), 32'd10);
    for (int k = 0; k < n; k++) chk($sformatf("cont_grant%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
    nxt(); v = 2'b00; smp();
    idle(2);

    // Back-to-back SB then LBU on the core port
    nxt(); v[0] = 1; wren[0] = 1; f3[0] = SB; addr[0] = 32'h0000_0100; wd[0] = 32'h0000_00AB;
    smp(); chk("b2b_accept1", 32'(ready), 32'h1); wrc = 32'(lwren);
    nxt(); wren[0] = 0; f3[0] = LBU; addr[0] = 32'h0000_0104;
    smp(); chk("b2b_issue_ready", 32'(ready), 32'h0); wrc += 32'(lwren);
    nxt();
    smp(); chk("b2b_rsp1", 32'(rspv), 32'h1); chk("b2b_accept2", 32'(ready), 32'h1); wrc += 32'(lwren);
    nxt(); v[0] = 0;
    smp(); chk("b2b_ld_addr", laddr, 32'h0000_0104); wrc += 32'(lwren);
    nxt(); smp(); wrc += 32'(lwren);
    nxt(); smp(); chk("b2b_rsp2", 32'(rspv), 32'h1); wrc += 32'(lwren);
    chk("b2b_wren_pulses", 32'(wrc), 32'd1);
    idle(2);

    // Reset during a store's ISSUE cycle
    nxt(); v[1] = 1; wren[1] = 1; f3[1] = SW; addr[1] = 32'h0002_0040; wd[1] = 32'h55;
    smp(); chk("rst_st_accept", 32'(ready), 32'h2);
    nxt(); v[1] = 0; rstn = 0;
    smp(); chk("rst_st_wren", 32'(lwren), 32'h0); chk("rst_st_rsp", 32'(rspv), 32'h0);
    nxt(); rstn = 1;
    smp(); chk("rst_after_rsp", 32'(rspv), 32'h0); chk("rst_after_addr", laddr, 32'h0);
    chk("rst_after_data", lsd, 32'h0); chk("rst_after_wren", 32'(lwren), 32'h0);
    chk("rst_after_rdata", rdata, 32'h0);
    nxt(); smp(); chk("rst_after2_rsp", 32'(rspv), 32'h0);
    idle(1);

    // Misaligned word load
    nxt(); v[0] = 1; wren[0] = 0; f3[0] = LW; addr[0] = 32'h0001_0002; ldd = 32'h1234_5678;
    smp(); chk("mis_accept", 32'(ready), 32'h1);
    nxt(); v[0] = 0;
    smp();
`ifdef LSU_ARB_MISALIGN_CHK_EN
    chk("mis_rsp", 32'(rspv), 32'h1); chk("mis_err", 32'(rerr), 32'h1);
    chk("mis_rdata", rdata, 32'h0); chk("mis_lsu_addr", laddr, 32'h0);
    chk("mis_lsu_wren", 32'(lwren), 32'h0);
`else
    chk("mis_fwd_addr", laddr, 32'h0001_0002); chk("mis_fwd_rsp", 32'(rspv), 32'h0);
    nxt(); smp(); nxt(); smp();
    chk("mis_fwd_rsp3", 32'(rspv), 32'h1); chk("mis_fwd_rdata", rdata, 32'h1234_5678);
`endif
    nxt(); ldd = 32'h0; smp();
    idle(2);

    // Randomized traffic on both ports
    for (int c = 0; c < 3000; c++) begin
      nxt();
      rstn = ($urandom_range(0, 199) != 0);
      ldd  = $urandom;
      for (int p = 0; p < 2; p++) begin
        if (m_acc[p]) v[p] = 0;
        if (!v[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            v[p]    = 1;
            wren[p] = $urandom_range(0, 1) == 1;
            f3[p]   = wren[p] ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
            addr[p] = $urandom;
            if ($urandom_range(0, 3) != 0) addr[p][1:0] = 2'b00;
            wd[p]   = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) v[p] = 0;
      end
      smp();
    end

    nxt(); v = 0; rstn = 1; smp();
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Shares the single load/store unit port between two requesters: port 0 = core pipeline MEM stage, port 1 = debug/boot loader.
- Uses valid/ready request handshakes and registered responses.
- Keeps one transaction in flight, holds LSU-side fields stable for the full access, and returns load data after the synchronous-RAM read latency.
- Sits between the requesters and the LSU; it drives the LSU's wren/funct3/addr/st_data inputs and reads its ld_data output.

Parameters:
- RD_LAT, 1, cycles from LSU address valid to ld_data valid (range 1..4).
- STARVE_MAX, 4, consecutive lost arbitrations after which port 1 is force-granted (range 1..15).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  2  request valid per port [0]=core, [1]=debug
- req_ready_o  out  2  request accepted per port
- req_wren_i  in  2  1=store, 0=load, per port
- req_funct3_i  in  2x3  RV32 load/store funct3, per port
- req_addr_i  in  2x32  byte address, per port
- req_wdata_i  in  2x32  store data, per port
- rsp_valid_o  out  2  one-cycle response pulse, per port
- rsp_rdata_o  out  32  load data, shared, qualified by rsp_valid_o
- lsu_wren_o  out  1  to LSU
- lsu_funct3_o  out  3  to LSU
- lsu_addr_o  out  32  to LSU
- lsu_st_data_o  out  32  to LSU
- lsu_ld_data_i  in  32  from LSU

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-low on rst_ni.
- Reset values: state IDLE; req_ready_o=0; rsp_valid_o=0; rsp_rdata_o=0; all lsu_* outputs 0; starvation counter 0.
- Address 0 in IDLE decodes to "select nothing" at the LSU.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o[i] = grant[i], combinational.
  - On accept (valid & ready) at cycle T, latch port id, wren, funct3, addr, wdata; go to ISSUE.
- ISSUE (T+1):
  - lsu_* driven from the latches.
  - lsu_wren_o = latched wren & rst_ni; it is never high in any other state.
  - Store → RESP. Load → WAIT.
- WAIT:
  - lsu_addr_o/lsu_funct3_o held; counter runs RD_LAT cycles.
  - On the last WAIT cycle (T+1+RD_LAT), capture lsu_ld_data_i into rsp_rdata_o; go to RESP.
- RESP:
  - rsp_valid_o[latched port]=1 for exactly one cycle. Store: rsp_rdata_o=0.
  - lsu_* return to 0.
  - Arbitration runs combinationally this cycle, so a new accept may coincide with the response pulse.
- Latency:
  - Load accepted at T → rsp_valid at T+2+RD_LAT.
  - Store accepted at T → write at T+1, rsp_valid at T+2.
  - Sustained throughput: one store per 2 cycles; one load per RD_LAT+2 cycles.
- Arbitration:
  - Port 0 has fixed priority.
  - Port 1 is granted when port 0 is not valid, or when the starvation counter == STARVE_MAX.
  - Counter increments on each arbitration (IDLE/RESP cycle) where port 1 is valid but port 0 wins.
  - Counter clears when port 1 is granted or req_valid_i[1]=0.
  - Counter saturates at STARVE_MAX.
- Requester rule: requesters hold valid and fields stable until accepted. Deasserting valid before accept is legal and causes no LSU activity.
- Simultaneous valid on both ports with counter < STARVE_MAX → port 0 wins; port 1 ready stays 0.
- Reset mid-operation:
  - Any state → IDLE at the clock edge.
  - An in-flight response is dropped (no rsp_valid).
  - A store in ISSUE while rst_ni=0 is suppressed (wren gated).

Optional Feature:
- Macro: LSU_ARB_MISALIGN_CHK_EN.
- With the macro:
  - Adds output rsp_err_o (1 bit, shared, qualified by rsp_valid_o).
  - Halfword with addr[0]=1, or word with addr[1:0]≠0, skips ISSUE/WAIT and goes straight to RESP.
  - That RESP has lsu_wren_o=0, rsp_rdata_o=0, rsp_err_o=1 at T+1.
  - Aligned accesses give rsp_err_o=0.
- Without the macro: no rsp_err_o port; misaligned requests are forwarded unchanged and the LSU's bank/offset truncation applies.

Decomposition:
- Package lsu_arb_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW
  - port index constants PORT_CORE=0, PORT_DBG=1
- Sub-module lsu_arb_prio: fixed-priority grant plus starvation counter. Inputs: req_valid, arb_en, clk/rst. Output: grant[1:0].

Test Plan:
- Core load only: port0 LW 0x0001_0010, RD_LAT=1, LSU returns 0xDEAD_BEEF at T+2 → rsp_valid_o[0] at T+3, rsp_rdata_o=0xDEAD_BEEF, lsu_wren_o never high.
- Debug store only: port1 SW 0x0002_0000 data 0x0000_03FF accepted T → lsu_wren_o=1 only at T+1 with those fields; rsp_valid_o[1] at T+2; lsu_addr_o=0 at T+2.
- Contention: both valid continuously, STARVE_MAX=4 → grants 0,0,0,0,1,0,0,0,0,1…; port1 ready only on the 5th arbitration.
- Back-to-back: port0 SB then LBU queued → second accept in the same cycle as the first rsp_valid; no idle bubble; lsu_wren_o single pulse.
- Reset: assert rst_ni=0 during a store's ISSUE cycle → lsu_wren_o=0, no rsp_valid, all outputs 0 next cycle, state IDLE.
- LSU_ARB_MISALIGN_CHK_EN: port0 LW addr 0x0001_0002 → rsp_valid_o[0] at T+1, rsp_err_o=1, rsp_rdata_o=0, no LSU activity. Same stimulus without the macro → normal load at T+3.
